// File: rtl/mem_responder.sv
// Memory-mapped slave with a programmable stall count and read latency.
// Backs on-chip RAM, an LED register and a read-only switch register.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   mem_addr           byte address (bit 0 ignored)
//   mem_read, mem_wr   requests, held by the initiator until accepted
//   mem_writedata      write data, valid with mem_wr
//   mem_wait           stall; a request is taken when mem_wait=0
//   mem_readdata       read data, zero unless mem_rddatavalid=1
//   mem_rddatavalid    one-cycle pulse per accepted read
//   sw                 switch inputs
//   ledr               LED register
module mem_responder #(
  parameter int WAIT_CYCLES  = 1,
  parameter int READ_LATENCY = 2,
  parameter int RAM_WORDS    = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] mem_addr,
  input  logic        mem_read,
  input  logic        mem_wr,
  input  logic [15:0] mem_writedata,
  output logic        mem_wait,
  output logic [15:0] mem_readdata,
  output logic        mem_rddatavalid,
  input  logic [9:0]  sw,
  output logic [9:0]  ledr
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam logic [3:0] STALL_LOAD =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [1:0] LAT_LOAD = 2'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    STALL,
    BUSY
  } state_t;

  state_t        state;
  logic [3:0]    stall_cnt;
  logic [1:0]    lat_cnt;
  logic [15:0]   data_q;
  logic [15:0]   ram [RAM_WORDS];

  logic          req;
  logic          accept;
  logic          sel_ram;
  logic          sel_led;
  logic          sel_sw;
  logic [15:0]   rd_val;
  logic [AW-1:0] ram_idx;
  logic          unused;

  assign req     = mem_read | mem_wr;
  assign ram_idx = mem_addr[AW:1];
  assign sel_ram = (mem_addr[15:12] == 4'h0);
  assign sel_led = (mem_addr[15:1] == 15'h0800);
  assign sel_sw  = (mem_addr[15:1] == 15'h0808);
  assign unused  = ^{mem_addr[0], mem_addr[11:1]};

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      sel_ram: rd_val = ram[ram_idx];
      sel_led: rd_val = {6'b0, ledr};
      sel_sw:  rd_val = {6'b0, sw};
      default: rd_val = '0;
    endcase
  end

  always_comb begin
    mem_wait = 1'b0;
    if (!reset) begin
      unique case (state)
        IDLE:    mem_wait = req && (WAIT_CYCLES != 0);
        STALL:   mem_wait = (stall_cnt != 4'd0);
        BUSY:    mem_wait = req;
        default: mem_wait = 1'b0;
      endcase
    end
  end

  // A request is taken either straight from IDLE (no stall configured)
  // or once the stall counter has run out with the request still held.
  assign accept = !reset && req &&
    ((state == IDLE && WAIT_CYCLES == 0) ||
     (state == STALL && stall_cnt == 4'd0));

  // RAM has no reset so its contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (accept && mem_wr && sel_ram)
      ram[ram_idx] <= mem_writedata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      stall_cnt       <= 4'd0;
      lat_cnt         <= 2'd0;
      data_q          <= '0;
      mem_rddatavalid <= 1'b0;
      mem_readdata    <= '0;
      ledr            <= '0;
    end else begin
      mem_rddatavalid <= 1'b0;
      mem_readdata    <= '0;
      unique case (state)
        IDLE: begin
          if (req && WAIT_CYCLES != 0) begin
            state     <= STALL;
            stall_cnt <= STALL_LOAD;
          end
        end
        STALL: begin
          if (!req)
            state <= IDLE;
          else if (stall_cnt != 4'd0)
            stall_cnt <= stall_cnt - 4'd1;
        end
        BUSY: begin
          // Outputs are registered, so the pulse is set up one
          // cycle before lat_cnt reaches zero.
          if (lat_cnt == 2'd1) begin
            mem_rddatavalid <= 1'b1;
            mem_readdata    <= data_q;
          end
          if (lat_cnt == 2'd0)
            state <= IDLE;
          else
            lat_cnt <= lat_cnt - 2'd1;
        end
        default: state <= IDLE;
      endcase
      if (accept) begin
        if (mem_wr) begin
          state <= IDLE;
          if (sel_led)
            ledr <= mem_writedata[9:0];
        end else begin
          state   <= BUSY;
          lat_cnt <= LAT_LOAD;
          data_q  <= rd_val;
          if (READ_LATENCY == 1) begin
            mem_rddatavalid <= 1'b1;
            mem_readdata    <= rd_val;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three parameter sets, directed scenarios and
// random traffic checked against a transaction-level memory model.
module tb_mem_responder;

  localparam int W [3]     = '{1, 0, 3};
  localparam int L [3]     = '{2, 1, 4};
  localparam int WORDS [3] = '{256, 256, 16};

  logic        clk = 1'b0;
  logic        reset [3];
  logic [15:0] mem_addr [3];
  logic        mem_read [3];
  logic        mem_wr [3];
  logic [15:0] mem_writedata [3];
  logic        mem_wait [3];
  logic [15:0] mem_readdata [3];
  logic        mem_rddatavalid [3];
  logic [9:0]  sw [3];
  logic [9:0]  ledr [3];

  int checks = 0;
  int failures = 0;

  logic [15:0] mref [3][2048];
  bit          known [3][2048];
  logic [9:0]  led_m [3];

  always #5 clk = ~clk;

  mem_responder #(.WAIT_CYCLES(1), .READ_LATENCY(2), .RAM_WORDS(256)) dut0 (
    .clk(clk), .reset(reset[0]), .mem_addr(mem_addr[0]),
    .mem_read(mem_read[0]), .mem_wr(mem_wr[0]),
    .mem_writedata(mem_writedata[0]), .mem_wait(mem_wait[0]),
    .mem_readdata(mem_readdata[0]), .mem_rddatavalid(mem_rddatavalid[0]),
    .sw(sw[0]), .ledr(ledr[0]));

  mem_responder #(.WAIT_CYCLES(0), .READ_LATENCY(1), .RAM_WORDS(256)) dut1 (
    .clk(clk), .reset(reset[1]), .mem_addr(mem_addr[1]),
    .mem_read(mem_read[1]), .mem_wr(mem_wr[1]),
    .mem_writedata(mem_writedata[1]), .mem_wait(mem_wait[1]),
    .mem_readdata(mem_readdata[1]), .mem_rddatavalid(mem_rddatavalid[1]),
    .sw(sw[1]), .ledr(ledr[1]));

  mem_responder #(.WAIT_CYCLES(3), .READ_LATENCY(4), .RAM_WORDS(16)) dut2 (
    .clk(clk), .reset(reset[2]), .mem_addr(mem_addr[2]),
    .mem_read(mem_read[2]), .mem_wr(mem_wr[2]),
    .mem_writedata(mem_writedata[2]), .mem_wait(mem_wait[2]),
    .mem_readdata(mem_readdata[2]), .mem_rddatavalid(mem_rddatavalid[2]),
    .sw(sw[2]), .ledr(ledr[2]));

  function automatic int word_idx(int k, logic [15:0] a);
    return (int'(a) / 2) % WORDS[k];
  endfunction

  function automatic bit is_ram(logic [15:0] a);
    return a < 16'h1000;
  endfunction

  function automatic logic [15:0] model_read(int k, logic [15:0] a);
    logic [15:0] ae;
    ae = a & 16'hFFFE;
    if (is_ram(a)) return mref[k][word_idx(k, a)];
    if (ae == 16'h1000) return {6'b0, led_m[k]};
    if (ae == 16'h1010) return {6'b0, sw[k]};
    return 16'h0000;
  endfunction

  task automatic model_write(int k, logic [15:0] a, logic [15:0] d);
    if (is_ram(a)) begin
      mref[k][word_idx(k, a)] = d;
      known[k][word_idx(k, a)] = 1'b1;
    end else if ((a & 16'hFFFE) == 16'h1000) begin
      led_m[k] = d[9:0];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction from IDLE; returns one cycle after acceptance
  // for a pure write, or after the read window for anything else.
  task automatic do_txn(input int k, input bit wr, input bit rd,
                        input logic [15:0] a, input logic [15:0] wd);
    int waits;
    bit acc;
    bit exp_v;
    int span;
    logic [15:0] exp_d;
    mem_addr[k] = a;
    mem_wr[k] = wr;
    mem_read[k] = rd;
    mem_writedata[k] = wd;
    waits = 0;
    acc = 0;
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk);
      if (mem_wait[k] === 1'b0) acc = 1;
      else waits++;
    end
    checks++;
    if (!acc || waits != W[k]) begin
      failures++;
      $display("FAIL wait_k%0d a=%h got waits=%0d acc=%0b exp waits=%0d",
               k, a, waits, acc, W[k]);
    end
    exp_v = rd && !wr;
    exp_d = model_read(k, a);
    if (wr) model_write(k, a, wd);
    step();
    mem_read[k] = 1'b0;
    mem_wr[k] = 1'b0;
    if (wr) begin
      checks++;
      if (ledr[k] !== led_m[k]) begin
        failures++;
        $display("FAIL ledr_k%0d got=%h exp=%h", k, ledr[k], led_m[k]);
      end
    end
    span = (wr && !rd) ? 0 : L[k] + 2;
    for (int j = 1; j <= span; j++) begin
      @(negedge clk);
      checks++;
      if (exp_v && j == L[k]) begin
        if (mem_rddatavalid[k] !== 1'b1 || mem_readdata[k] !== exp_d) begin
          failures++;
          $display("FAIL rdata_k%0d a=%h got v=%b d=%h exp v=1 d=%h",
                   k, a, mem_rddatavalid[k], mem_readdata[k], exp_d);
        end
      end else if (mem_rddatavalid[k] !== 1'b0 || mem_readdata[k] !== 16'h0) begin
        failures++;
        $display("FAIL idle_rdata_k%0d a=%h cyc=%0d got v=%b d=%h exp v=0 d=0",
                 k, a, j, mem_rddatavalid[k], mem_readdata[k]);
      end
    end
    if (span != 0) step();
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      reset[k] = 1'b1;
      mem_read[k] = 1'b1;
      mem_addr[k] = 16'h0010;
      step();
      @(negedge clk);
      checks++;
      if (mem_wait[k] !== 1'b0 || mem_rddatavalid[k] !== 1'b0 ||
          mem_readdata[k] !== 16'h0 || ledr[k] !== 10'h0) begin
        failures++;
        $display("FAIL reset_k%0d got wait=%b v=%b d=%h led=%h exp all 0",
                 k, mem_wait[k], mem_rddatavalid[k], mem_readdata[k], ledr[k]);
      end
      mem_read[k] = 1'b0;
      step();
      reset[k] = 1'b0;
      step();
      @(negedge clk);
      checks++;
      if (mem_wait[k] !== 1'b0) begin
        failures++;
        $display("FAIL idle_wait_k%0d got=%b exp=0", k, mem_wait[k]);
      end
      step();
    end
  endtask

  task automatic test_basic_timing();
    do_txn(0, 1'b1, 1'b0, 16'h0010, 16'h1234);
    do_txn(0, 1'b0, 1'b1, 16'h0010, 16'h0000);
  endtask

  task automatic test_same_addr();
    do_txn(1, 1'b1, 1'b0, 16'h0020, 16'h5A5A);
    do_txn(1, 1'b0, 1'b1, 16'h0020, 16'h0000);
    do_txn(1, 1'b1, 1'b0, 16'h0020, 16'hC3C3);
    do_txn(1, 1'b0, 1'b1, 16'h0021, 16'h0000);
  endtask

  task automatic test_back_to_back();
    logic [15:0] da;
    logic [15:0] db;
    da = 16'($urandom);
    db = 16'($urandom);
    do_txn(1, 1'b1, 1'b0, 16'h0000, da);
    do_txn(1, 1'b1, 1'b0, 16'h0002, db);
    mem_read[1] = 1'b1;
    mem_addr[1] = 16'h0000;
    @(negedge clk);
    checks++;
    if (mem_wait[1] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first_wait got=%b exp=0", mem_wait[1]);
    end
    step();
    mem_addr[1] = 16'h0002;
    @(negedge clk);
    checks++;
    if (mem_wait[1] !== 1'b1 || mem_rddatavalid[1] !== 1'b1 ||
        mem_readdata[1] !== da) begin
      failures++;
      $display("FAIL b2b_busy got wait=%b v=%b d=%h exp wait=1 v=1 d=%h",
               mem_wait[1], mem_rddatavalid[1], mem_readdata[1], da);
    end
    step();
    @(negedge clk);
    checks++;
    if (mem_wait[1] !== 1'b0 || mem_rddatavalid[1] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second_accept got wait=%b v=%b exp wait=0 v=0",
               mem_wait[1], mem_rddatavalid[1]);
    end
    step();
    mem_read[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_rddatavalid[1] !== 1'b1 || mem_readdata[1] !== db) begin
      failures++;
      $display("FAIL b2b_second_data got v=%b d=%h exp v=1 d=%h",
               mem_rddatavalid[1], mem_readdata[1], db);
    end
    step();
    @(negedge clk);
    checks++;
    if (mem_rddatavalid[1] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_tail got v=%b exp=0", mem_rddatavalid[1]);
    end
    step();
  endtask

  task automatic test_io();
    do_txn(0, 1'b1, 1'b0, 16'h1000, 16'h03FF);
    sw[0] = 10'h155;
    do_txn(0, 1'b0, 1'b1, 16'h1010, 16'h0000);
    do_txn(0, 1'b0, 1'b1, 16'h2000, 16'h0000);
    do_txn(0, 1'b0, 1'b1, 16'h1000, 16'h0000);
  endtask

  task automatic test_rw_both();
    do_txn(0, 1'b1, 1'b1, 16'h0004, 16'hBEEF);
    do_txn(0, 1'b0, 1'b1, 16'h0004, 16'h0000);
  endtask

  task automatic test_reset_busy();
    bit acc;
    mem_read[0] = 1'b1;
    mem_addr[0] = 16'h0010;
    acc = 0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (mem_wait[0] === 1'b0) acc = 1;
      else step();
    end
    step();
    reset[0] = 1'b1;
    mem_read[0] = 1'b0;
    led_m[0] = 10'h0;
    for (int j = 1; j <= L[0] + 2; j++) begin
      @(negedge clk);
      checks++;
      if (!acc || mem_rddatavalid[0] !== 1'b0) begin
        failures++;
        $display("FAIL reset_busy_valid cyc=%0d acc=%0b got v=%b exp=0",
                 j, acc, mem_rddatavalid[0]);
      end
      if (j == 2) reset[0] = 1'b0;
    end
    checks++;
    if (ledr[0] !== 10'h0) begin
      failures++;
      $display("FAIL reset_busy_ledr got=%h exp=0", ledr[0]);
    end
    step();
    do_txn(0, 1'b0, 1'b1, 16'h0010, 16'h0000);
  endtask

  task automatic test_stall();
    do_txn(2, 1'b1, 1'b0, 16'h0006, 16'h7E57);
    do_txn(2, 1'b0, 1'b1, 16'h0006, 16'h0000);
    mem_read[2] = 1'b1;
    mem_addr[2] = 16'h0006;
    @(negedge clk);
    checks++;
    if (mem_wait[2] !== 1'b1) begin
      failures++;
      $display("FAIL drop_wait0 got=%b exp=1", mem_wait[2]);
    end
    step();
    @(negedge clk);
    checks++;
    if (mem_wait[2] !== 1'b1) begin
      failures++;
      $display("FAIL drop_wait1 got=%b exp=1", mem_wait[2]);
    end
    step();
    mem_read[2] = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);
      checks++;
      if (mem_rddatavalid[2] !== 1'b0) begin
        failures++;
        $display("FAIL drop_valid cyc=%0d got=%b exp=0", j, mem_rddatavalid[2]);
      end
      step();
    end
    @(negedge clk);
    checks++;
    if (mem_wait[2] !== 1'b0) begin
      failures++;
      $display("FAIL drop_idle_wait got=%b exp=0", mem_wait[2]);
    end
    step();
    do_txn(2, 1'b0, 1'b1, 16'h0006, 16'h0000);
  endtask

  task automatic test_reset_stall();
    mem_wr[2] = 1'b1;
    mem_addr[2] = 16'h0006;
    mem_writedata[2] = 16'hDEAD;
    @(negedge clk);
    step();
    reset[2] = 1'b1;
    step();
    reset[2] = 1'b0;
    mem_wr[2] = 1'b0;
    step();
    do_txn(2, 1'b0, 1'b1, 16'h0006, 16'h0000);
  endtask

  task automatic test_random();
    logic [15:0] pool [14];
    logic [15:0] a;
    bit wr;
    bit rd;
    int op;
    pool = '{16'h0000, 16'h0002, 16'h0010, 16'h0046, 16'h0100, 16'h0FFE,
             16'h0011, 16'h1000, 16'h1001, 16'h1010, 16'h1011, 16'h2000,
             16'h1002, 16'hF010};
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 25; n++) begin
        a = pool[$urandom_range(0, 13)];
        op = $urandom_range(0, 2);
        wr = (op != 1);
        rd = (op != 0);
        if (!wr && is_ram(a) && !known[k][word_idx(k, a)]) begin
          wr = 1'b1;
          rd = 1'b0;
        end
        sw[k] = 10'($urandom);
        do_txn(k, wr, rd, a, 16'($urandom));
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      reset[k] = 1'b1;
      mem_addr[k] = 16'h0;
      mem_read[k] = 1'b0;
      mem_wr[k] = 1'b0;
      mem_writedata[k] = 16'h0;
      sw[k] = 10'h0;
      led_m[k] = 10'h0;
      for (int i = 0; i < 2048; i++) begin
        mref[k][i] = 16'h0;
        known[k][i] = 1'b0;
      end
    end
    step();
    test_reset();
    test_basic_timing();
    test_same_addr();
    test_back_to_back();
    test_io();
    test_rw_both();
    test_reset_busy();
    test_stall();
    test_reset_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
